// File: rtl/pipeline_arith_pkg.sv
// Shared constants and width helpers for the pipeline_arith_hs datapath.
// Widths are functions of the operand width N so every stage sizes itself consistently.
package pipeline_arith_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int x3_width(input int n);
      return n + 3;
   endfunction

   function automatic int full_width(input int n);
      return 2 * n + 3;
   endfunction

endpackage

// File: rtl/pipe_ctrl_slice.sv
// One pipeline stage's occupancy bit with ready/valid chaining.
// `load` means the stage register may capture this edge: it is empty or its content moves on.
module pipe_ctrl_slice (
   input  logic clk,
   input  logic rst_n,
   input  logic up_valid,
   input  logic down_ready,
   output logic valid,
   output logic load
);

   assign load = !valid || down_ready;

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n)
         valid <= 1'b0;
      else if (load)
         valid <= up_valid;
   end

endmodule

// File: rtl/pipeline_arith_hs.sv
// Three-stage handshaked datapath computing F = ((A+B) +/- (C-D)) * D.
// Define PIPELINE_ARITH_SAT_EN to clamp F to the OW-bit signed range; otherwise F wraps.
module pipeline_arith_hs
   import pipeline_arith_pkg::*;
#(
   parameter int N  = 10,
   parameter int OW = 2 * N + 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  A,
   input  logic [N-1:0]  B,
   input  logic [N-1:0]  C,
   input  logic [N-1:0]  D,
   input  logic          op,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [OW-1:0] F,
   output logic          out_sat,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    count
);

   localparam int XW = x3_width(N);
   localparam int FW = full_width(N);

   logic v1, v2, v3;
   logic ld1, ld2, ld3;

   pipe_ctrl_slice u_s1 (.clk(clk), .rst_n(rst_n), .up_valid(in_valid), .down_ready(ld2),
                         .valid(v1), .load(ld1));
   pipe_ctrl_slice u_s2 (.clk(clk), .rst_n(rst_n), .up_valid(v1), .down_ready(ld3),
                         .valid(v2), .load(ld2));
   pipe_ctrl_slice u_s3 (.clk(clk), .rst_n(rst_n), .up_valid(v2), .down_ready(out_ready),
                         .valid(v3), .load(ld3));

   assign in_ready  = ld1 && rst_n;
   assign out_valid = v3;
   assign count     = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};

   // Stage 1: operand pre-add / pre-subtract
   logic        [N:0]   x1_q;
   logic signed [N:0]   x2_q;
   logic        [N-1:0] d1_q;
   logic                op1_q;

   // NOTE: interior datapath registers carry no reset; the valid bits alone say whether they mean anything.
   always_ff @(posedge clk) begin
      if (ld1 && in_valid) begin
         x1_q  <= {1'b0, A} + {1'b0, B};
         x2_q  <= $signed({1'b0, C} - {1'b0, D});
         d1_q  <= D;
         op1_q <= op;
      end
   end

   // Stage 2: combine, sized so the worst case cannot overflow
   logic signed [XW-1:0] x1_e, x2_e, x3_d, x3_q;
   logic        [N-1:0]  d2_q;

   assign x1_e = XW'({1'b0, x1_q});
   assign x2_e = XW'(x2_q);
   assign x3_d = (op1_q == OP_SUB) ? x1_e - x2_e : x1_e + x2_e;

   always_ff @(posedge clk) begin
      if (ld2 && v1) begin
         x3_q <= x3_d;
         d2_q <= d1_q;
      end
   end

   // Stage 3: full-precision product, then reduce to OW bits
   logic signed [FW-1:0] p_full;
   logic        [OW-1:0] f_d;
   logic                 sat_d;

   assign p_full = FW'(x3_q) * FW'($signed({1'b0, d2_q}));

`ifdef PIPELINE_ARITH_SAT_EN
   localparam logic [OW-1:0] F_MAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] F_MIN = {1'b1, {(OW-1){1'b0}}};
   logic fits;

   // In range exactly when every bit above the OW-bit sign position repeats the sign.
   assign fits  = (&p_full[FW-1:OW-1]) || !(|p_full[FW-1:OW-1]);
   assign f_d   = fits ? p_full[OW-1:0] : (p_full[FW-1] ? F_MIN : F_MAX);
   assign sat_d = !fits;
`else
   assign f_d   = p_full[OW-1:0];
   assign sat_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         F       <= '0;
         out_sat <= 1'b0;
      end else if (ld3 && v2) begin
         F       <= f_d;
         out_sat <= sat_d;
      end
   end

endmodule

// File: doc/pipeline_arith_hs.md
PIPELINE_ARITH_HS -- requirements
Module: pipeline_arith_hs

Interface
REQ-001 SHALL have parameter N, default 10, operand width in bits (N >= 2).
REQ-002 SHALL have parameter OW, default 2*N+3, output width in bits (OW >= 8, OW <= 2*N+3).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have ports A, B, C and D, each input, N bits, unsigned operands.
REQ-006 SHALL have port op, input, 1 bit, per-transaction mode: 0 = add, 1 = subtract.
REQ-007 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit, forming the input handshake.
REQ-008 SHALL have port F, output, OW bits, the signed two's-complement result.
REQ-009 SHALL have port out_sat, output, 1 bit, set when F was clamped.
REQ-010 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit, forming the output handshake.
REQ-011 SHALL have port count, output, 2 bits, the number of occupied pipeline stages (0..3).

Function
REQ-012 SHALL accept a transaction on any rising edge where in_valid=1 and in_ready=1; a result transfers on any edge where out_valid=1 and out_ready=1.
REQ-013 Stage 1 SHALL compute x1=A+B (N+1 bits, unsigned) and x2=C-D (N+1 bits, signed), and register D and op.
REQ-014 Stage 2 SHALL compute x3=x1+x2 when op=0 and x3=x1-x2 when op=1, as an N+3-bit signed value with no overflow.
REQ-015 Stage 3 SHALL compute P=x3*D as a full-precision 2N+3-bit signed product, then reduce P to OW bits per REQ-024/REQ-025.
REQ-016 Latency SHALL be 3 cycles from acceptance to out_valid=1 when no stall occurs; throughput SHALL be 1 transaction per cycle.
REQ-017 Each stage SHALL hold a valid bit; a stage SHALL advance when it is empty or when its downstream stage advances or is empty.
REQ-018 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing); it is combinational, with no skid buffer.
REQ-019 While out_valid=1 and out_ready=0, F, out_sat and out_valid SHALL hold stable.
REQ-020 Results SHALL leave the block in acceptance order; no transaction is dropped or duplicated.
REQ-021 count SHALL equal the number of stage valid bits set after each edge; on a simultaneous accept and output transfer, count is unchanged.
REQ-022 in_ready SHALL be 0 while rst_n=0.

Reset
REQ-023 On a rising edge with rst_n=0, all stage valid bits, out_valid, count, F and out_sat SHALL be 0; in-flight transactions are discarded, including when reset is asserted mid-stream.

Configuration
REQ-024 With PIPELINE_ARITH_SAT_EN defined, if P exceeds the OW-bit signed range, F SHALL be the clamped maximum or minimum value and out_sat=1; otherwise out_sat=0.
REQ-025 Without PIPELINE_ARITH_SAT_EN, F SHALL be P[OW-1:0] (wrap) and out_sat SHALL be tied to 0.

Structure
REQ-026 Package pipeline_arith_pkg SHALL hold the op encoding constants (OP_ADD=0, OP_SUB=1) and width functions: x3 width N+3, full width 2N+3.
REQ-027 The stage valid/advance logic SHALL be one sub-module, pipe_ctrl_slice, instantiated three times; the datapath registers are inline.

Verification
REQ-028 N=10; A=5, B=3, C=10, D=2, op=0, out_ready=1 -> 3 cycles later F=32, out_sat=0.
REQ-029 Same operands with op=1 -> F=0.
REQ-030 A=0, B=0, C=0, D=1023, op=0 -> F=-1046529.
REQ-031 OW=16; A=B=C=1023, D=100, op=0 (P=296900) -> with the macro F=32767, out_sat=1; without it F=-30780, out_sat=0.
REQ-032 Back-to-back in_valid with out_ready=0 for 6 cycles -> exactly 3 accepted, in_ready=0, count=3; after out_ready=1 all results emerge in order, one per cycle.
REQ-033 rst_n=0 for one edge with count=2 -> next cycle out_valid=0, count=0, F=0; a new transaction then completes with 3-cycle latency.
